mem_arbiter: RTL and testbench

Shares the single processor–memory port between the instruction-cache subsystem (prefetcher/MSHR request stream) and the data cache. Each cycle it picks at most one requester. By default the data cache has priority, with a starvation counter that guarantees instruction-fetch progress. It records which requester owns every accepted load tag, so each returned memory block reaches only its owner. It sits between the cache subsystems and the memory model.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single processor-memory port between the icache
// request stream and the data cache. Dcache has default priority. A saturating
// starvation counter lets icache through after STARVE_LIMIT consecutive losses.
// A tag-owner table routes each returned load block to the cache that issued it.

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_arbiter_pkg;
  typedef logic [31:0] ADDR;
  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;
  typedef struct packed {
    logic valid;
    ADDR  addr;
  } I_ADDR_PACKET;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = `NUM_MEM_TAGS
) (
  input  logic         clock,
  input  logic         reset,
  input  I_ADDR_PACKET icache_req_addr,
  output logic         icache_req_accepted,
  output MEM_TAG       icache_req_tag,
  output MEM_TAG       icache_data_tag,
  input  logic         dcache_req_valid,
  input  MEM_COMMAND   dcache_req_cmd,
  input  ADDR          dcache_req_addr,
  input  MEM_BLOCK     dcache_req_data,
  output logic         dcache_req_accepted,
  output MEM_TAG       dcache_req_tag,
  output MEM_TAG       dcache_data_tag,
  output MEM_BLOCK     mem_data,
  output MEM_COMMAND   proc2mem_command,
  output ADDR          proc2mem_addr,
  output MEM_BLOCK     proc2mem_data,
  input  MEM_TAG       mem2proc_transaction_tag,
  input  MEM_BLOCK     mem2proc_data,
  input  MEM_TAG       mem2proc_data_tag
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  // Bit 0 is never set: tag 0 means "no tag".
  logic [NUM_TAGS:0] owner_valid;
  logic [NUM_TAGS:0] owner_is_icache;

  logic grant_icache;
  logic grant_dcache;
  logic mem_accept;
  logic acc_load;
  logic acc_in_range;
  logic ret_hit;

  assign mem_accept   = (mem2proc_transaction_tag != '0);
  assign acc_in_range = (int'(mem2proc_transaction_tag) <= NUM_TAGS);

  // Pick at most one requester; a starved icache overrides dcache priority.
  always_comb begin
    grant_icache = 1'b0;
    grant_dcache = 1'b0;
    if ((starve_cnt == CNT_W'(STARVE_LIMIT)) && icache_req_addr.valid) begin
      grant_icache = 1'b1;
    end else if (dcache_req_valid) begin
      grant_dcache = 1'b1;
    end else if (icache_req_addr.valid) begin
      grant_icache = 1'b1;
    end
  end

  // Drive the memory port from the winner; loads carry no data.
  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_icache) begin
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = icache_req_addr.addr;
    end else if (grant_dcache) begin
      proc2mem_command = dcache_req_cmd;
      proc2mem_addr    = dcache_req_addr;
      if (dcache_req_cmd == MEM_STORE) begin
        proc2mem_data = dcache_req_data;
      end
    end
  end

  // Acceptance and tag go only to the granted requester.
  always_comb begin
    icache_req_accepted = grant_icache && mem_accept;
    dcache_req_accepted = grant_dcache && mem_accept;
    icache_req_tag      = icache_req_accepted ? mem2proc_transaction_tag : '0;
    dcache_req_tag      = dcache_req_accepted ? mem2proc_transaction_tag : '0;
    acc_load            = acc_in_range &&
                          (icache_req_accepted ||
                           (dcache_req_accepted && (dcache_req_cmd == MEM_LOAD)));
  end

  // Route a returned tag to its registered owner; unowned tags are dropped.
  always_comb begin
    ret_hit         = (mem2proc_data_tag != '0) &&
                      (int'(mem2proc_data_tag) <= NUM_TAGS) &&
                      owner_valid[mem2proc_data_tag];
    icache_data_tag = '0;
    dcache_data_tag = '0;
    if (ret_hit) begin
      if (owner_is_icache[mem2proc_data_tag]) begin
        icache_data_tag = mem2proc_data_tag;
      end else begin
        dcache_data_tag = mem2proc_data_tag;
      end
    end
  end

  assign mem_data = mem2proc_data;

  // Count consecutive icache losses; a rejected icache grant leaves it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!icache_req_addr.valid || icache_req_accepted) begin
      starve_cnt <= '0;
    end else if (grant_dcache) begin
      if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Owner table: clear on return, then set on a new load so a re-issued tag
  // in the same cycle belongs to its new owner (later assignment wins).
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_valid     <= '0;
      owner_is_icache <= '0;
    end else begin
      if (ret_hit) begin
        owner_valid[mem2proc_data_tag] <= 1'b0;
      end
      if (acc_load) begin
        owner_valid[mem2proc_transaction_tag]     <= 1'b1;
        owner_is_icache[mem2proc_transaction_tag] <= grant_icache;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the stimulus process pushes hand-computed
// expected port values per active cycle; a monitor pops and compares them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  I_ADDR_PACKET icache_req_addr;
  logic         icache_req_accepted;
  MEM_TAG       icache_req_tag;
  MEM_TAG       icache_data_tag;
  logic         dcache_req_valid;
  MEM_COMMAND   dcache_req_cmd;
  ADDR          dcache_req_addr;
  MEM_BLOCK     dcache_req_data;
  logic         dcache_req_accepted;
  MEM_TAG       dcache_req_tag;
  MEM_TAG       dcache_data_tag;
  MEM_BLOCK     mem_data;
  MEM_COMMAND   proc2mem_command;
  ADDR          proc2mem_addr;
  MEM_BLOCK     proc2mem_data;
  MEM_TAG       mem2proc_transaction_tag;
  MEM_BLOCK     mem2proc_data;
  MEM_TAG       mem2proc_data_tag;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .icache_req_addr          (icache_req_addr),
    .icache_req_accepted      (icache_req_accepted),
    .icache_req_tag           (icache_req_tag),
    .icache_data_tag          (icache_data_tag),
    .dcache_req_valid         (dcache_req_valid),
    .dcache_req_cmd           (dcache_req_cmd),
    .dcache_req_addr          (dcache_req_addr),
    .dcache_req_data          (dcache_req_data),
    .dcache_req_accepted      (dcache_req_accepted),
    .dcache_req_tag           (dcache_req_tag),
    .dcache_data_tag          (dcache_data_tag),
    .mem_data                 (mem_data),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    MEM_COMMAND cmd;
    ADDR        addr;
    MEM_BLOCK   data;
    logic       i_acc;
    MEM_TAG     i_tag;
    logic       d_acc;
    MEM_TAG     d_tag;
    MEM_TAG     i_dt;
    MEM_TAG     d_dt;
    MEM_BLOCK   mdata;
  } obs_t;

  localparam ADDR      IA  = 32'h200;
  localparam ADDR      IA2 = 32'h240;
  localparam ADDR      DA  = 32'h300;
  localparam MEM_BLOCK RB  = 64'hDA7A_0000_0000_0000;
  localparam MEM_BLOCK Z   = 64'h0;

  obs_t         exp_q[$];
  logic [95:0]  nm_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  logic         done        = 1'b0;

  // One cycle of stimulus plus its expected response (pushed only when the
  // cycle is expected to show activity on the port or a returned tag).
  task automatic cyc(input logic iv, input ADDR ia, input logic dv, input MEM_COMMAND dc,
                     input ADDR da, input MEM_BLOCK dd, input MEM_TAG mt, input MEM_TAG rt,
                     input MEM_COMMAND ecmd, input ADDR eaddr, input MEM_BLOCK edata,
                     input logic eia, input logic eda, input MEM_TAG eidt, input MEM_TAG eddt,
                     input logic [95:0] nm);
    obs_t e;
    icache_req_addr.valid    = iv;
    icache_req_addr.addr     = ia;
    dcache_req_valid         = dv;
    dcache_req_cmd           = dc;
    dcache_req_addr          = da;
    dcache_req_data          = dd;
    mem2proc_transaction_tag = mt;
    mem2proc_data_tag        = rt;
    mem2proc_data            = RB | MEM_BLOCK'(rt);
    e.cmd   = ecmd;
    e.addr  = eaddr;
    e.data  = edata;
    e.i_acc = eia;
    e.i_tag = eia ? mt : 4'd0;
    e.d_acc = eda;
    e.d_tag = eda ? mt : 4'd0;
    e.i_dt  = eidt;
    e.d_dt  = eddt;
    e.mdata = RB | MEM_BLOCK'(rt);
    if (ecmd != MEM_NONE || rt != 4'd0) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input MEM_TAG rt, input MEM_TAG eidt, input MEM_TAG eddt, input logic [95:0] nm);
    cyc(0, 0, 0, MEM_NONE, 0, Z, 0, rt, MEM_NONE, 0, Z, 0, 0, eidt, eddt, nm);
  endtask

  // Both caches request loads; iw selects which one is expected to win.
  task automatic both(input ADDR ia, input MEM_TAG mt, input MEM_TAG rt, input logic iw,
                      input logic acc, input logic [95:0] nm);
    cyc(1, ia, 1, MEM_LOAD, DA, Z, mt, rt, MEM_LOAD, iw ? ia : DA, Z,
        iw && acc, !iw && acc, 0, 0, nm);
  endtask

  // Monitor: compare whenever the DUT shows port activity or a return.
  initial begin
    obs_t        got;
    obs_t        e;
    logic [95:0] nm;
    forever begin
      @(negedge clock);
      if (done) begin
        if (exp_q.size() != 0) begin
          vectors++;
          miscompares++;
          $display("FAIL missing_outputs: got no DUT activity, required %0d more vectors", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
      got.cmd   = proc2mem_command;
      got.addr  = proc2mem_addr;
      got.data  = proc2mem_data;
      got.i_acc = icache_req_accepted;
      got.i_tag = icache_req_tag;
      got.d_acc = dcache_req_accepted;
      got.d_tag = dcache_req_tag;
      got.i_dt  = icache_data_tag;
      got.d_dt  = dcache_data_tag;
      got.mdata = mem_data;
      if (got.cmd != MEM_NONE || mem2proc_data_tag != 4'd0 || got.i_dt != 4'd0 ||
          got.d_dt != 4'd0 || got.i_acc || got.d_acc) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_activity: got %h, required no activity", got);
        end else begin
          e  = exp_q.pop_front();
          nm = nm_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL %0s: got cmd=%0d addr=%h data=%h iacc=%b itag=%0d dacc=%b dtag=%0d idt=%0d ddt=%0d mdata=%h, required cmd=%0d addr=%h data=%h iacc=%b itag=%0d dacc=%b dtag=%0d idt=%0d ddt=%0d mdata=%h",
                     nm, got.cmd, got.addr, got.data, got.i_acc, got.i_tag, got.d_acc, got.d_tag, got.i_dt, got.d_dt, got.mdata,
                     e.cmd, e.addr, e.data, e.i_acc, e.i_tag, e.d_acc, e.d_tag, e.i_dt, e.d_dt, e.mdata);
          end else begin
            $display("vec %0d %0s ok: cmd=%0d addr=%h itag=%0d dtag=%0d idt=%0d ddt=%0d",
                     vectors, nm, got.cmd, got.addr, got.i_tag, got.d_tag, got.i_dt, got.d_dt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1;
    idle(0, 0, 0, "rst_idle");
    idle(3, 0, 0, "rst_ret3");
    reset = 1'b0;

    // Dcache-only load, store data suppressed, then routed return.
    cyc(0, 0, 1, MEM_LOAD, 32'h100, 64'hBAD, 3, 0, MEM_LOAD, 32'h100, Z, 0, 1, 0, 0, "d_load3");
    idle(3, 0, 3, "d_ret3");

    // Continuous contention: four dcache wins, then icache, repeating.
    both(IA, 1,  0, 0, 1, "starve_d1");
    both(IA, 2,  0, 0, 1, "starve_d2");
    both(IA, 4,  0, 0, 1, "starve_d3");
    both(IA, 6,  0, 0, 1, "starve_d4");
    both(IA, 8,  0, 1, 1, "starve_i5");
    both(IA, 9,  0, 0, 1, "starve_d6");
    both(IA, 10, 0, 0, 1, "starve_d7");
    both(IA, 11, 0, 0, 1, "starve_d8");
    both(IA, 12, 0, 0, 1, "starve_d9");
    both(IA, 13, 0, 1, 1, "starve_i10");
    idle(8,  8,  0, "ret_i8");
    idle(13, 13, 0, "ret_i13");
    idle(1,  0,  1, "ret_d1");
    idle(1,  0,  0, "ret1_dup");

    // Counter holds while icache is granted but rejected by memory.
    both(IA2, 14, 0, 0, 1, "hold_d1");
    both(IA2, 15, 0, 0, 1, "hold_d2");
    cyc(1, IA2, 0, MEM_NONE, 0, Z, 0, 0, MEM_LOAD, IA2, Z, 0, 0, 0, 0, "i_rej1");
    cyc(1, IA2, 0, MEM_NONE, 0, Z, 0, 0, MEM_LOAD, IA2, Z, 0, 0, 0, 0, "i_rej2");
    cyc(1, IA2, 0, MEM_NONE, 0, Z, 0, 0, MEM_LOAD, IA2, Z, 0, 0, 0, 0, "i_rej3");
    both(IA2, 3,  0, 0, 1, "hold_d3");
    both(IA2, 1,  0, 0, 1, "hold_d4");
    both(IA2, 13, 0, 1, 1, "hold_i");

    // Store creates no owner entry; its return is dropped.
    cyc(0, 0, 1, MEM_STORE, 32'h400, 64'hCAFE, 5, 0, MEM_STORE, 32'h400, 64'hCAFE, 0, 1, 0, 0, "d_store5");
    idle(5, 0, 0, "ret_store5");

    // Tag 7 returned to icache and re-issued to dcache in the same cycle.
    cyc(1, 32'h280, 0, MEM_NONE, 0, Z, 7, 0, MEM_LOAD, 32'h280, Z, 1, 0, 0, 0, "i_load7");
    cyc(0, 0, 1, MEM_LOAD, 32'h500, Z, 7, 7, MEM_LOAD, 32'h500, Z, 0, 1, 7, 0, "swap7");
    idle(7, 0, 7, "ret7_d");

    // Mid-operation reset with tags 2 and 4 outstanding and a nonzero counter.
    both(IA, 5, 0, 0, 1, "pre_rst");
    reset = 1'b1;
    both(IA, 0, 0, 0, 0, "in_rst");
    reset = 1'b0;
    both(IA, 1, 2, 0, 1, "rst_drop2");
    both(IA, 3, 4, 0, 1, "rst_drop4");
    both(IA, 6, 0, 0, 1, "post_d3");
    both(IA, 7, 0, 0, 1, "post_d4");
    both(IA, 8, 0, 1, 1, "post_i5");

    idle(0, 0, 0, "tail");
    done = 1'b1;
  end

endmodule
